data_mem_resp: RTL and testbench

- Data-memory responder serving the core's load/store port: the memory end of the MemWr/MemOP/ALU-address path.
- Accepts one request at a time on a valid/ready channel.
- Waits a programmable number of cycles, then commits the store or performs the load with RV32 size and sign handling.
- Returns the result on a valid/ready response channel; holds a word-organised local array.

---
 rtl/mem_pkg.sv | 9 +
 rtl/data_mem_resp_if.sv | 21 ++
 rtl/mem_lane_align.sv | 30 +++
 rtl/data_mem_resp.sv | 83 ++++++++
 tb/tb_data_mem_resp.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: RV32 MemOP (funct3) encodings and data_mem_resp FSM states
package mem_pkg;
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} state_t;
endpackage

// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if: valid/ready request (addr, wen, memop, wdata) and response (rdata, err) channels; master = core, slave = memory
interface data_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [2:0]  req_memop;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master(
    output req_valid, req_addr, req_wen, req_memop, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave(
    input  req_valid, req_addr, req_wen, req_memop, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables/store alignment, load select/extend and format errors (in: memop, lane, wen, wdata, rword; out: be, wdata_al, rdata, fmt_err)
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  lane,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata,
  output logic        fmt_err
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b        = rword[8*lane +: 8];
    h        = lane[1] ? rword[31:16] : rword[15:0];
    wdata_al = memop == MEMOP_B ? {4{wdata[7:0]}} : memop == MEMOP_H ? {2{wdata[15:0]}} : wdata;
    be       = memop == MEMOP_B ? 4'b0001 << lane : memop == MEMOP_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    rdata    = memop == MEMOP_B  ? {{24{b[7]}}, b} :
               memop == MEMOP_BU ? {24'b0, b} :
               memop == MEMOP_H  ? {{16{h[15]}}, h} :
               memop == MEMOP_HU ? {16'b0, h} : rword;
    fmt_err  = memop == 3'b011 || memop[2:1] == 2'b11 || (wen && memop[2]) ||
               ((memop == MEMOP_H || memop == MEMOP_HU) && lane[0]) ||
               (memop == MEMOP_W && lane != 2'b00);
  end
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: latency-programmable RV32 data-memory responder (clk, rst active-low async, bus = slave side of data_mem_resp_if)
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h80000000,
  parameter int          LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  data_mem_resp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     addr, wdata, off, wdata_al, rdata;
  logic            wen, range_err, fmt_err, err;
  logic [2:0]      memop;
  logic [3:0]      be;
  logic [AW-1:0]   idx;
  logic [31:0]     mem [DEPTH];
  assign off       = addr - BASE;
  assign idx       = off[AW+1:2];
  assign range_err = |off[31:AW+2];
  assign err       = range_err | fmt_err;
  mem_lane_align u_align (
    .memop    (memop),
    .lane     (off[1:0]),
    .wen      (wen),
    .wdata    (wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wdata_al (wdata_al),
    .rdata    (rdata),
    .fmt_err  (fmt_err)
  );
  always_ff @(posedge clk)
    if (state == COMMIT && wen && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      addr           <= '0;
      wdata          <= '0;
      wen            <= 1'b0;
      memop          <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.req_valid) begin
            addr          <= bus.req_addr;
            wen           <= bus.req_wen;
            memop         <= bus.req_memop;
            wdata         <= bus.req_wdata;
            cnt           <= CW'(LATENCY == 0 ? 0 : LATENCY - 1);
            state         <= LATENCY == 0 ? COMMIT : WAIT;
            bus.req_ready <= 1'b0;
          end
        WAIT: begin
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? COMMIT : WAIT;
        end
        COMMIT: begin
          bus.resp_rdata <= err || wen ? 32'h0 : rdata;
          bus.resp_err   <= err;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        default:
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: randomized + directed bench against a byte-array reference model (LATENCY=2 and LATENCY=0 instances)
module tb_data_mem_resp;
  import mem_pkg::*;
  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          DEPTH = 1024;
  logic clk = 0, rst = 0, sel = 0;
  logic req_valid = 0, req_wen = 0, resp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0] req_memop = 0;
  logic rq, rv, re;
  logic [31:0] rd;
  int n_tests = 0, n_fail = 0;
  logic [7:0] mb [2][4*DEPTH];
  data_mem_resp_if i0 ();
  data_mem_resp_if i1 ();
  assign i0.req_valid = req_valid & ~sel;
  assign i1.req_valid = req_valid & sel;
  assign i0.req_addr = req_addr;
  assign i1.req_addr = req_addr;
  assign i0.req_wen = req_wen;
  assign i1.req_wen = req_wen;
  assign i0.req_memop = req_memop;
  assign i1.req_memop = req_memop;
  assign i0.req_wdata = req_wdata;
  assign i1.req_wdata = req_wdata;
  assign i0.resp_ready = resp_ready;
  assign i1.resp_ready = resp_ready;
  assign rq = sel ? i1.req_ready : i0.req_ready;
  assign rv = sel ? i1.resp_valid : i0.resp_valid;
  assign re = sel ? i1.resp_err : i0.resp_err;
  assign rd = sel ? i1.resp_rdata : i0.resp_rdata;
  data_mem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(i0.slave));
  data_mem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(i1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model(input int s, input logic [31:0] a, input logic w, input logic [2:0] op,
                       input logic [31:0] d, output logic [31:0] r, output logic e);
    logic [31:0] off, v;
    int sz;
    off = a - BASE;
    sz = op[1:0] == 2'd0 ? 1 : op[1:0] == 2'd1 ? 2 : 4;
    e = off >= 4 * DEPTH || op == 3 || op >= 6 || (w && op >= 4) || (off % sz != 0);
    r = 0;
    if (!e) begin
      if (w)
        for (int i = 0; i < sz; i++) mb[s][off+i] = d[8*i +: 8];
      else begin
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (32'(mb[s][off+i]) << (8 * i));
        if (op < 3 && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
        r = v;
      end
    end
  endtask
  task automatic xact(input logic [31:0] a, input logic w, input logic [2:0] op,
                      input logic [31:0] d, input int hold, output logic [31:0] got);
    logic [31:0] er, held;
    logic ee;
    int n;
    model(sel, a, w, op, d, er, ee);
    @(negedge clk);
    chk("req_ready_idle", rq, 1);
    req_valid = 1; req_addr = a; req_wen = w; req_memop = op; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0; req_addr = $urandom; req_wen = 1'($urandom);
    req_memop = 3'($urandom); req_wdata = $urandom;
    n = 1;
    while (!rv && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, (sel ? 0 : 2) + 2);
    chk("resp_err", re, ee);
    chk("resp_rdata", rd, er);
    got = rd;
    held = rd;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1; req_addr = BASE + 32'h10; req_wen = 1; req_memop = MEMOP_W; req_wdata = 0;
      @(posedge clk); #1;
      chk("bp_valid", rv, 1);
      chk("bp_rdata", rd, held);
      chk("bp_req_ready", rq, 0);
    end
    req_valid = 0;
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    if (hold > 0) begin
      chk("rel_valid", rv, 0);
      chk("rel_req_ready", rq, 1);
    end
  endtask
  initial begin
    logic [31:0] g, a;
    logic [2:0] op;
    #22;
    chk("rst_req_ready", rq, 1);
    chk("rst_resp_valid", rv, 0);
    chk("rst_rdata", rd, 0);
    chk("rst_err", re, 0);
    @(negedge clk) rst = 1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      xact(BASE + 32'h20, 1, MEMOP_W, 32'h11111111, 0, g);
      for (int wd = 16; wd < 32; wd++) xact(BASE + 32'(4 * wd), 1, MEMOP_W, $urandom, 0, g);
      for (int t = 0; t < 50; t++) begin
        a = BASE + 32'h40 + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 9) == 0) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) a = BASE - 32'($urandom_range(1, 8));
        op = 3'($urandom_range(0, 7));
        xact(a, 1'($urandom), op, $urandom, $urandom_range(0, 2), g);
      end
    end
    sel = 0;
    xact(BASE + 32'h10, 1, MEMOP_W, 32'hDEADBEEF, 0, g);
    chk("sw_rdata_zero", g, 0);
    xact(BASE + 32'h10, 0, MEMOP_W, 0, 0, g);
    chk("lw_deadbeef", g, 32'hDEADBEEF);
    xact(BASE + 32'h13, 0, MEMOP_B, 0, 0, g);
    chk("lb_sign", g, 32'hFFFFFFDE);
    xact(BASE + 32'h13, 0, MEMOP_BU, 0, 0, g);
    chk("lbu_zero", g, 32'h000000DE);
    xact(BASE + 32'h12, 0, MEMOP_H, 0, 0, g);
    chk("lh_sign", g, 32'hFFFFDEAD);
    xact(BASE + 32'h10, 0, MEMOP_HU, 0, 0, g);
    chk("lhu_zero", g, 32'h0000BEEF);
    xact(BASE + 32'h11, 1, MEMOP_B, 32'h12345677, 0, g);
    xact(BASE + 32'h10, 0, MEMOP_W, 0, 0, g);
    chk("sb_merge", g, 32'hDEAD77EF);
    xact(BASE + 32'h12, 1, MEMOP_H, 32'h0000AAAA, 0, g);
    xact(BASE + 32'h10, 0, MEMOP_W, 0, 0, g);
    chk("sh_merge", g, 32'hAAAA77EF);
    xact(BASE + 32'h02, 0, MEMOP_W, 0, 0, g);
    xact(BASE + 32'h11, 1, MEMOP_H, 32'h5555, 0, g);
    xact(BASE + 32'(4 * DEPTH), 0, MEMOP_W, 0, 0, g);
    xact(32'h7FFFFFFC, 0, MEMOP_W, 0, 0, g);
    xact(BASE + 32'h10, 1, 3'b011, 32'h0, 0, g);
    xact(BASE + 32'h10, 1, MEMOP_BU, 32'h0, 0, g);
    xact(BASE + 32'h10, 0, MEMOP_W, 0, 5, g);
    chk("err_no_change", g, 32'hAAAA77EF);
    xact(BASE + 32'h10, 0, MEMOP_W, 0, 0, g);
    chk("bp_store_ignored", g, 32'hAAAA77EF);
    @(negedge clk);
    req_valid = 1; req_addr = BASE + 32'h20; req_wen = 1; req_memop = MEMOP_W; req_wdata = 32'h22222222;
    @(posedge clk); #1;
    req_valid = 0;
    chk("wait_req_ready", rq, 0);
    rst = 0;
    #1;
    chk("mid_rst_req_ready", rq, 1);
    chk("mid_rst_resp_valid", rv, 0);
    chk("mid_rst_rdata", rd, 0);
    chk("mid_rst_err", re, 0);
    @(negedge clk) rst = 1;
    xact(BASE + 32'h20, 0, MEMOP_W, 0, 0, g);
    chk("rst_store_discarded", g, 32'h11111111);
    sel = 1;
    xact(BASE + 32'h40, 1, MEMOP_W, 32'hCAFEF00D, 0, g);
    xact(BASE + 32'h40, 0, MEMOP_W, 0, 2, g);
    chk("lat0_lw", g, 32'hCAFEF00D);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
